// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared score width, default win score and game state encoding
package snake_pkg;
  localparam int SCORE_W       = 7;
  localparam int DEF_MAX_SCORE = 99;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OVER = 2'd1,
    WIN  = 2'd2
  } state_t;
endpackage

// File: rtl/score_ctrl_if.sv
// rtl/score_ctrl_if.sv - button inputs and score/status outputs of score_ctrl
interface score_ctrl_if;
  import snake_pkg::*;

  logic               goodCollButton;
  logic               badCollButton;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] highScore;
  logic               scorePulse;
  logic               gameOver;
  logic               win;
  logic               blinkToggle;

  modport master (
    output goodCollButton, badCollButton,
    input  score, highScore, scorePulse, gameOver, win, blinkToggle
  );

  modport slave (
    input  goodCollButton, badCollButton,
    output score, highScore, scorePulse, gameOver, win, blinkToggle
  );
endinterface

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer with rising-edge detect for one button
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic edge_pulse
);
  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       armed;
  logic [1:0] fill;

  // armed only after a genuine low sample, so a button held through reset stays silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && !sync2) begin
        armed <= 1'b1;
      end
    end
  end

  assign edge_pulse = armed & sync2 & ~prev;
endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - RUN/OVER/WIN score state machine with lockout and blink divider
module score_ctrl
  import snake_pkg::*;
#(
  parameter int BLINK_DIV = 50,
  parameter int LOCKOUT   = 8,
  parameter int MAX_SCORE = DEF_MAX_SCORE
) (
  input  logic          clk,
  input  logic          rst,
  score_ctrl_if.slave   bus
);
  localparam int LW = ($clog2(LOCKOUT + 1) > 0) ? $clog2(LOCKOUT + 1) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [LW-1:0]      LOCK_LOAD = LW'(LOCKOUT);
  localparam logic [BW-1:0]      BLINK_END = BW'(BLINK_DIV - 1);
  localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] LAST_S    = SCORE_W'(MAX_SCORE - 1);

  state_t             state;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] high_q;
  logic               pulse_q;
  logic               over_q;
  logic               win_q;
  logic               blink_q;
  logic [LW-1:0]      lock_q;
  logic [BW-1:0]      blink_cnt;
  logic               good_edge;
  logic               bad_edge;
  logic               good_ok;
  logic               bad_ok;

  btn_sync_edge u_good (.clk(clk), .rst_n(rst), .btn(bus.goodCollButton), .edge_pulse(good_edge));
  btn_sync_edge u_bad  (.clk(clk), .rst_n(rst), .btn(bus.badCollButton),  .edge_pulse(bad_edge));

  assign good_ok = good_edge && (lock_q == '0);
  assign bad_ok  = bad_edge  && (lock_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      score_q   <= '0;
      high_q    <= '0;
      pulse_q   <= 1'b0;
      over_q    <= 1'b0;
      win_q     <= 1'b0;
      blink_q   <= 1'b1;
      lock_q    <= '0;
      blink_cnt <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (lock_q != '0) begin
        lock_q <= lock_q - 1'b1;
      end
      if (state != RUN) begin
        if (blink_cnt == BLINK_END) begin
          blink_cnt <= '0;
          blink_q   <= ~blink_q;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      case (state)
        RUN: begin
          // bad takes priority over a simultaneous good edge
          if (bad_ok) begin
            state     <= OVER;
            over_q    <= 1'b1;
            blink_q   <= 1'b0;
            blink_cnt <= '0;
            lock_q    <= LOCK_LOAD;
            if (score_q > high_q) begin
              high_q <= score_q;
            end
          end else if (good_ok) begin
            lock_q  <= LOCK_LOAD;
            pulse_q <= 1'b1;
            if (score_q >= LAST_S) begin
              score_q   <= MAX_S;
              high_q    <= MAX_S;
              state     <= WIN;
              over_q    <= 1'b1;
              win_q     <= 1'b1;
              blink_q   <= 1'b0;
              blink_cnt <= '0;
            end else begin
              score_q <= score_q + 1'b1;
            end
          end
        end
        default: begin
          if (good_ok) begin
            state     <= RUN;
            score_q   <= '0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            blink_q   <= 1'b1;
            blink_cnt <= '0;
            lock_q    <= LOCK_LOAD;
          end
        end
      endcase
    end
  end

  assign bus.score       = score_q;
  assign bus.highScore   = high_q;
  assign bus.scorePulse  = pulse_q;
  assign bus.gameOver    = over_q;
  assign bus.win         = win_q;
  assign bus.blinkToggle = blink_q;
endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameter BLINK_DIV, default 50: clk cycles per blinkToggle half-period in OVER/WIN.
REQ-002 Parameter LOCKOUT, default 8: cycles after an accepted event during which new button edges are discarded.
REQ-003 Parameter MAX_SCORE, default 99: score value that ends the game as a win.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 goodCollButton  input  1  asynchronous good-collision request; level, may be held.
REQ-007 badCollButton  input  1  asynchronous bad-collision request; level, may be held.
REQ-008 score  output  7  current score, binary, range 0..MAX_SCORE; feeds score_display.
REQ-009 highScore  output  7  best score since reset, binary.
REQ-010 scorePulse  output  1  one-cycle strobe on the edge where score increments.
REQ-011 gameOver  output  1  high in OVER or WIN.
REQ-012 win  output  1  high only in WIN.
REQ-013 blinkToggle  output  1  display enable; constant 1 in RUN, toggling in OVER/WIN.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer; an edge = sync2 high and previous sync2 low.
REQ-015 An accepted edge SHALL update state/score on the 3rd rising clk edge, counting the first edge that samples the button high.
REQ-016 Held buttons SHALL produce exactly one edge per low-to-high transition.
REQ-017 FSM states: RUN, OVER, WIN; encoding in shared package.
REQ-018 RUN + good edge, score < MAX_SCORE-1: score += 1, scorePulse = 1 that cycle, stay RUN.
REQ-019 RUN + good edge, score = MAX_SCORE-1: score = MAX_SCORE, scorePulse = 1, go to WIN.
REQ-020 RUN + bad edge: score unchanged, go to OVER.
REQ-021 Good and bad edges in the same cycle: bad wins, no increment.
REQ-022 On entering OVER or WIN: highScore = max(highScore, score) at the same edge.
REQ-023 OVER/WIN + good edge: score = 0, go to RUN, highScore kept, no scorePulse; bad edges ignored.
REQ-024 Every accepted edge (RUN, OVER, WIN) SHALL load the lockout counter with LOCKOUT; while nonzero, all edges are discarded (not queued).
REQ-025 Blink divider SHALL clear and set blinkToggle = 0 on entering OVER/WIN, then invert blinkToggle every BLINK_DIV cycles.
REQ-026 Score SHALL never exceed MAX_SCORE and never wrap.
REQ-027 scorePulse SHALL never be high outside RUN or for more than one cycle per edge.

Reset
REQ-028 rst low SHALL immediately force: state RUN, score 0, highScore 0, scorePulse 0, gameOver 0, win 0, blinkToggle 1, lockout 0, blink divider 0, synchronizer flops 0.
REQ-029 Reset mid-lockout or mid-blink SHALL discard all pending counts; a button held through reset release SHALL produce no edge until released and pressed again.
REQ-030 Deassertion SHALL be synchronized to clk by the instantiating level; score_ctrl treats rst as raw asynchronous.

Structure
REQ-031 Package snake_pkg SHALL hold the state enum (RUN/OVER/WIN), SCORE_W = 7 and default MAX_SCORE.
REQ-032 One sub-module, btn_sync_edge (2-flop sync + rising-edge detect), instantiated once per button.
REQ-033 Counters: lockout width clog2(LOCKOUT+1); blink divider width clog2(BLINK_DIV).

Verification
REQ-034 Reset, then 5 good pulses (1 cycle high, 10 low) -> score 5, five single-cycle scorePulse, gameOver 0, blinkToggle 1.
REQ-035 Score 3, bad pulse -> gameOver 1 on 3rd edge, highScore 3, blinkToggle 0 then 1 after 50 cycles, 0 after 100.
REQ-036 OVER, good pulse -> RUN, score 0, highScore 3; good pulses to score 2 then bad -> highScore stays 3.
REQ-037 Good and bad raised same cycle in RUN at score 4 -> OVER, score 4, no scorePulse.
REQ-038 Good held 200 cycles -> exactly one increment; second press 3 cycles after first accepted edge -> discarded.
REQ-039 99 good pulses from reset -> score 99, win 1, gameOver 1, highScore 99; further good pulse -> score 0, RUN.
